// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode sequencer: owns the PC and instruction register and walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Optional retired-instruction counter is built when INSTR_SEQ_RETIRE_CNT_EN is defined.
module instr_sequencer #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              IMEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic            alu_zero,
    output logic [3:0]      estado,
    output logic [2:0]      tipo,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]     retired
`endif
);

    localparam logic [3:0] S_IDLE      = 4'b0000;
    localparam logic [3:0] S_FETCH     = 4'b0001;
    localparam logic [3:0] S_DECODE    = 4'b0011;
    localparam logic [3:0] S_EXECUTE   = 4'b0010;
    localparam logic [3:0] S_MEMORY    = 4'b0100;
    localparam logic [3:0] S_WRITEBACK = 4'b1111;
    localparam logic [3:0] S_HALT      = 4'b1000;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

    logic [3:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            imem_req_q, imem_req_d;

    logic [6:0]      opcode;
    logic            legal_op;
    logic            br_taken;
    logic [PC_W-1:0] imm_b;

    assign opcode   = ir_q[6:0];
    assign legal_op = (opcode == OP_IMM) || (opcode == OP_LD) ||
                      (opcode == OP_REG) || (opcode == OP_BR);
    assign imm_b    = {{(PC_W-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    // Only beq/bne are resolved; every other branch funct3 falls through.
    assign br_taken = (opcode == OP_BR) &&
                      (((ir_q[14:12] == 3'b000) &&  alu_zero) ||
                       ((ir_q[14:12] == 3'b001) && !alu_zero));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    cnt_d   = 8'd0;
                    state_d = S_DECODE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d     = cnt_q + 8'd1;
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (legal_op) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXECUTE: begin
                state_d = (opcode == OP_LD) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (dmem_ack) state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d    = br_taken ? (pc_q + imm_b) : (pc_q + PC_W'(4));
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request is registered: high for exactly the cycles spent in FETCH.
    assign imem_req_d = (state_d == S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0013;
            cnt_q      <= 8'd0;
            illegal_q  <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            imem_req_q <= imem_req_d;
        end
    end

`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    assign retired_d = (state_q == S_WRITEBACK) ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_q <= 32'd0;
        else        retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

    assign estado    = state_q;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign imem_req  = imem_req_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign tipo      = ir_q[6:4];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign rd        = ir_q[11:7];
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];

endmodule
